// File: rtl/sirv_spi_slave_link.sv
// Single-lane SPI responder: oversampled SCK/CS_N/MOSI, RX/TX byte FIFOs, watermark interrupts.
// Optional error reporting (ip_rxovf, ip_txunf, err_clear) is enabled by defining SPI_SLAVE_ERR_EN.
module sirv_spi_slave_link #(
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  FILL  = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_sck_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe,
    input  logic       ctrl_cpol,
    input  logic       ctrl_cpha,
    input  logic       ctrl_endian,
    input  logic [3:0] ctrl_wm_tx,
    input  logic [3:0] ctrl_wm_rx,
    output logic       io_tx_ready,
    input  logic       io_tx_valid,
    input  logic [7:0] io_tx_bits,
    input  logic       io_rx_ready,
    output logic       io_rx_valid,
    output logic [7:0] io_rx_bits,
    output logic       ip_txwm,
    output logic       ip_rxwm,
    output logic       busy
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic       ip_rxovf,
    output logic       ip_txunf,
    input  logic       err_clear
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  FULL_CNT = 4'(DEPTH);

    typedef enum logic {IDLE, SEL} state_t;

    state_t         state;
    logic           sck_s1, sck_s2, sck_d;
    logic           cs_s1, cs_s2, cs_d;
    logic           mosi_s1, mosi_s2;
    logic           cpol_q, cpha_q, endian_q;
    logic [2:0]     bit_cnt;
    logic           reload_pend;
    logic           miso_oe;
    logic [7:0]     tx_sr, rx_sr;
    logic           rx_push;
    logic [7:0]     rx_push_data;

    logic [7:0]     tx_mem [DEPTH];
    logic [7:0]     rx_mem [DEPTH];
    logic [AW-1:0]  tx_wr, tx_rd, rx_wr, rx_rd;
    logic [3:0]     tx_count, rx_count;

    // NOTE: every clocked block uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_s1  <= 1'b0;  sck_s2  <= 1'b0;  sck_d <= 1'b0;
            cs_s1   <= 1'b1;  cs_s2   <= 1'b1;  cs_d  <= 1'b1;
            mosi_s1 <= 1'b0;  mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spi_sck_i;  sck_s2  <= sck_s1;  sck_d <= sck_s2;
            cs_s1   <= spi_cs_n_i; cs_s2   <= cs_s1;   cs_d  <= cs_s2;
            mosi_s1 <= spi_mosi_i; mosi_s2 <= mosi_s1;
        end
    end

    // Leading edge leaves the idle level; cpha picks which edge samples and which shifts.
    logic sck_rise, sck_fall, lead_evt, trail_evt;
    logic enter, leave, sample_evt, shift_evt, load_evt, byte_done;
    logic tx_empty, rx_full, tx_push, tx_pop, rx_wr_en, rx_pop;
    logic [7:0] rx_next, load_byte;

    assign sck_rise   = sck_s2 & ~sck_d;
    assign sck_fall   = ~sck_s2 & sck_d;
    assign lead_evt   = cpol_q ? sck_fall : sck_rise;
    assign trail_evt  = cpol_q ? sck_rise : sck_fall;
    assign enter      = (state == IDLE) && cs_d && !cs_s2;
    assign leave      = (state == SEL) && !cs_d && cs_s2;
    assign sample_evt = (state == SEL) && !leave && (cpha_q ? trail_evt : lead_evt);
    assign shift_evt  = (state == SEL) && !leave && (cpha_q ? lead_evt : trail_evt);
    assign load_evt   = (enter && !ctrl_cpha) || (shift_evt && reload_pend);
    assign byte_done  = sample_evt && (bit_cnt == 3'd7);
    assign rx_next    = endian_q ? {mosi_s2, rx_sr[7:1]} : {rx_sr[6:0], mosi_s2};

    assign tx_empty   = (tx_count == 4'd0);
    assign rx_full    = (rx_count == FULL_CNT);
    assign load_byte  = tx_empty ? FILL : tx_mem[tx_rd];
    assign tx_push    = io_tx_valid && io_tx_ready;
    assign tx_pop     = load_evt && !tx_empty;
    assign rx_wr_en   = rx_push && !rx_full;
    assign rx_pop     = io_rx_ready && io_rx_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            endian_q     <= 1'b0;
            bit_cnt      <= 3'd0;
            reload_pend  <= 1'b0;
            miso_oe      <= 1'b0;
            tx_sr        <= 8'hFF;
            rx_sr        <= 8'h00;
            rx_push      <= 1'b0;
            rx_push_data <= 8'h00;
        end else begin
            rx_push <= byte_done;
            if (byte_done)
                rx_push_data <= rx_next;
            case (state)
                IDLE: if (enter) begin
                    state       <= SEL;
                    cpol_q      <= ctrl_cpol;
                    cpha_q      <= ctrl_cpha;
                    endian_q    <= ctrl_endian;
                    bit_cnt     <= 3'd0;
                    miso_oe     <= 1'b1;
                    reload_pend <= ctrl_cpha;
                    if (!ctrl_cpha)
                        tx_sr <= load_byte;
                end
                SEL: if (leave) begin
                    state       <= IDLE;
                    bit_cnt     <= 3'd0;
                    reload_pend <= 1'b0;
                    miso_oe     <= 1'b0;
                    rx_sr       <= 8'h00;
                end else begin
                    if (sample_evt) begin
                        rx_sr   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            reload_pend <= 1'b1;
                    end
                    if (shift_evt) begin
                        if (reload_pend) begin
                            tx_sr       <= load_byte;
                            reload_pend <= 1'b0;
                        end else begin
                            tx_sr <= endian_q ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; pointers and counts alone define what is valid.
    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wr] <= io_tx_bits;
        if (rx_wr_en)
            rx_mem[rx_wr] <= rx_push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= 4'd0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= 4'd0;
        end else begin
            if (tx_push)  tx_wr <= tx_wr + AW'(1);
            if (tx_pop)   tx_rd <= tx_rd + AW'(1);
            if (rx_wr_en) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)   rx_rd <= rx_rd + AW'(1);
            tx_count <= tx_count + 4'(tx_push) - 4'(tx_pop);
            rx_count <= rx_count + 4'(rx_wr_en) - 4'(rx_pop);
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    // A new error event in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ip_rxovf <= 1'b0;
            ip_txunf <= 1'b0;
        end else begin
            ip_rxovf <= (rx_push && rx_full) || (ip_rxovf && !err_clear);
            ip_txunf <= (load_evt && tx_empty) || (ip_txunf && !err_clear);
        end
    end
`endif

    assign spi_miso_oe = miso_oe;
    assign spi_miso_o  = miso_oe ? (endian_q ? tx_sr[0] : tx_sr[7]) : 1'b1;
    assign io_tx_ready = (tx_count != FULL_CNT);
    assign io_rx_valid = (rx_count != 4'd0);
    assign io_rx_bits  = rx_mem[rx_rd];
    assign ip_txwm     = (tx_count < ctrl_wm_tx);
    assign ip_rxwm     = (rx_count > ctrl_wm_rx);
    assign busy        = (state == SEL);

endmodule
